interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Collects interrupt requests from on-chip peripherals and drives the processor's single edge-sensitive `int` input. Requests are edge-captured into a pending register and filtered by a software-written enable mask. The highest-priority enabled request is issued as a fixed-width `int` pulse. No further request is issued until the processor reports completion on `int_done`, which is driven by the processor's WB-stage interrupt indication, or until a timeout expires. The block sits directly upstream of the processor; its `int_id` output is muxed onto the processor's 16-bit `In_Port`.

## Interface
Parameters:
- NUM_SRC, 4: number of request sources (1..8).
- PULSE_LEN, 2: cycles `int` is held high per issued interrupt (≥1).
- TIMEOUT, 64: maximum WAIT_DONE cycles before forced recovery (≥1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- irq_req  in  NUM_SRC  level requests from peripherals, synchronous to clk; bit 0 has highest priority.
- int_done  in  1  processor has completed interrupt entry (WB-stage flag); sampled only in ASSERT/WAIT_DONE.
- cfg_we  in  1  write strobe for the configuration word.
- cfg_data  in  16  configuration word: [NUM_SRC-1:0] enable mask; [15] clear all pending (write-1); [14] clear err (write-1).
- int  out  1  interrupt line to processor (registered).
- int_id  out  16  index of the last granted source, zero-extended (registered).
- busy  out  1  1 when state ≠ IDLE.
- err  out  1  sticky timeout flag.

## Operation
- Edge capture: `irq_prev` holds the previous `irq_req`. A rise is `irq_req & ~irq_prev`. Every rise sets `pending[i]` regardless of enable.
- Grant: in IDLE, if `pending & enable` ≠ 0, pick the lowest set index. Clear that pending bit, load `int_id`, go to ASSERT.
- Set/clear collision on the same pending bit in the same cycle: set wins.
- cfg write (`cfg_we`=1): load enable from cfg_data[NUM_SRC-1:0].
  - cfg_data[15]=1 clears all pending; a rise in the same cycle still sets its bit.
  - cfg_data[14]=1 clears err.
  - The new enable takes effect for the grant decision on the next edge.
- FSM states IDLE, ASSERT, WAIT_DONE, GAP:
  - IDLE: int=0. Grant → ASSERT.
  - ASSERT: int=1 for exactly PULSE_LEN cycles (counter).
    - If int_done was seen at any point during ASSERT, go to GAP at the end of the pulse.
    - Otherwise go to WAIT_DONE.
  - WAIT_DONE: int=0. Timeout counter increments each cycle.
    - int_done=1 → GAP.
    - Counter reaches TIMEOUT without int_done → err<=1, go to GAP.
  - GAP: exactly one cycle, int=0, then → IDLE. Consecutive pulses are always separated by ≥1 low cycle, so the processor sees a new posedge.
- int_done in IDLE or GAP is ignored.
- Pending requests accumulate while busy; a source re-requested before service yields a single interrupt.

## Timing
- Reset (reset=0 at an edge):
  - State → IDLE; int=0, int_id=0, busy=0, err=0, pending=0, enable=0, counters=0.
  - `irq_prev` loads the current `irq_req`, so levels held high through reset produce no rise.
- Reset takes priority over every other event, including mid-ASSERT: int is low after that edge.
- Latency, with the rise first sampled at edge E0 and the source enabled and the FSM in IDLE:
  - pending set at E0.
  - int=1 and int_id valid after E1.
  - int falls after E(1+PULSE_LEN).
- Completion: int_done=1 sampled at edge Ek in WAIT_DONE → GAP after Ek, IDLE after Ek+1. The earliest next int rise is after Ek+2.
- Timeout: err rises at the edge that counts the TIMEOUT-th WAIT_DONE cycle; the transition to GAP happens at that same edge.
- busy tracks state registered; busy=0 exactly when state is IDLE.

## Test plan
- Basic: enable=0xF; raise irq_req[2] at E0 → int high after E1 for 2 cycles, int_id=0x0002; int_done pulse 3 cycles later → GAP one cycle, busy=0 two edges after int_done.
- Priority: irq_req[3] and irq_req[1] rise on the same edge → first int with int_id=1; after int_done, a second int with int_id=3, with ≥1 low cycle between pulses.
- Mask: enable=0x1; irq_req[2] rises → no int, pending[2]=1; write enable=0x4 → int with int_id=2 two edges after the write.
- Timeout: TIMEOUT=8, never assert int_done → err=1 on the 8th WAIT_DONE cycle, FSM returns to IDLE; cfg write with bit14=1 → err=0.
- Reset: hold irq_req[0]=1 and assert reset during ASSERT → int=0 next edge; release reset with irq_req still 1 → no int issued.
- Early done: int_done=1 during the first ASSERT cycle → no WAIT_DONE cycles; GAP directly after the pulse, IDLE one cycle later.

Source files
------------

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-captured, masked, fixed-priority interrupt issuer with done/timeout handshake
//
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   reset     - synchronous active-low reset
//   irq_req   - level requests from peripherals; bit 0 has the highest priority
//   int_done  - processor finished interrupt entry (WB-stage flag); only looked at in ASSERT/WAIT_DONE
//   cfg_we    - configuration write strobe
//   cfg_data  - [NUM_SRC-1:0] enable mask, [15] clear all pending, [14] clear err
//   int_line  - registered interrupt line to the processor (the "int" output; that name is a reserved word)
//   int_id    - index of the last granted source, zero-extended to 16 bits
//   busy      - 1 whenever the FSM is not in IDLE
//   err       - sticky timeout flag
module interrupt_controller #(
    parameter int NUM_SRC   = 4,
    parameter int PULSE_LEN = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic               int_done,
    input  logic               cfg_we,
    input  logic [15:0]        cfg_data,
    output logic               int_line,
    output logic [15:0]        int_id,
    output logic               busy,
    output logic               err
);

    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ASSERT    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [PW-1:0]      pulse_cnt;
    logic [TW-1:0]      tmo_cnt;
    logic               done_seen;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant_oh;
    logic [NUM_SRC-1:0] pending_next;
    logic               grant_valid;
    logic [15:0]        grant_id;
    logic               cfg_unused;

    // Configuration bits between the mask and the command bits carry no meaning.
    assign cfg_unused = &{1'b0, cfg_data[13:NUM_SRC]};

    assign rise = irq_req & ~irq_prev;
    assign req  = pending & enable;

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        grant_oh    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_valid = 1'b1;
                grant_id    = 16'(i);
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
            end
        end
    end

    // Clears first, then a same-cycle rise re-sets its bit (set wins).
    always_comb begin
        pending_next = pending;
        if (cfg_we && cfg_data[15]) begin
            pending_next = '0;
        end
        if (state == IDLE && grant_valid) begin
            pending_next = pending_next & ~grant_oh;
        end
        pending_next = pending_next | rise;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            irq_prev  <= irq_req;   // levels held through reset must not look like a rise
            pending   <= '0;
            enable    <= '0;
            pulse_cnt <= '0;
            tmo_cnt   <= '0;
            done_seen <= 1'b0;
            int_line  <= 1'b0;
            int_id    <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            irq_prev <= irq_req;
            pending  <= pending_next;

            if (cfg_we) begin
                enable <= cfg_data[NUM_SRC-1:0];
                if (cfg_data[14]) begin
                    err <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state     <= ASSERT;
                        int_line  <= 1'b1;
                        int_id    <= grant_id;
                        busy      <= 1'b1;
                        pulse_cnt <= '0;
                        done_seen <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (pulse_cnt == PW'(PULSE_LEN - 1)) begin
                        int_line  <= 1'b0;
                        tmo_cnt   <= '0;
                        done_seen <= 1'b0;
                        state     <= (done_seen || int_done) ? GAP : WAIT_DONE;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                        done_seen <= done_seen | int_done;
                    end
                end
                WAIT_DONE: begin
                    if (int_done) begin
                        state <= GAP;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        // A timeout on the same edge as a software clear still reports.
                        err   <= 1'b1;
                        state <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    int_line <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed self-checking bench for interrupt_controller
module tb_interrupt_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_req;
    logic        int_done;
    logic        cfg_we;
    logic [15:0] cfg_data;
    logic        int_line;
    logic [15:0] int_id;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    interrupt_controller #(
        .NUM_SRC  (4),
        .PULSE_LEN(2),
        .TIMEOUT  (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_req (irq_req),
        .int_done(int_done),
        .cfg_we  (cfg_we),
        .cfg_data(cfg_data),
        .int_line(int_line),
        .int_id  (int_id),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
        cfg_data = '0;
    endtask

    initial begin
        reset    = 1'b0;
        irq_req  = '0;
        int_done = 1'b0;
        cfg_we   = 1'b0;
        cfg_data = '0;
        step();
        step();
        check("reset_int",  {15'd0, int_line}, 16'd0);
        check("reset_id",   int_id, 16'd0);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_err",  {15'd0, err}, 16'd0);
        reset = 1'b1;
        step();

        // Basic: source 2, done three cycles into WAIT_DONE
        cfg_write(16'h000F);
        irq_req = 4'b0100;
        step();
        check("basic_e0_int", {15'd0, int_line}, 16'd0);
        check("basic_e0_busy", {15'd0, busy}, 16'd0);
        step();
        check("basic_e1_int", {15'd0, int_line}, 16'd1);
        check("basic_e1_id", int_id, 16'd2);
        check("basic_e1_busy", {15'd0, busy}, 16'd1);
        step();
        check("basic_e2_int", {15'd0, int_line}, 16'd1);
        step();
        check("basic_e3_int", {15'd0, int_line}, 16'd0);
        check("basic_e3_busy", {15'd0, busy}, 16'd1);
        irq_req = '0;
        step();
        step();
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        check("basic_gap_busy", {15'd0, busy}, 16'd1);
        check("basic_gap_int", {15'd0, int_line}, 16'd0);
        step();
        check("basic_idle_busy", {15'd0, busy}, 16'd0);

        // Priority: sources 3 and 1 together
        irq_req = 4'b1010;
        step();
        step();
        check("prio_first_int", {15'd0, int_line}, 16'd1);
        check("prio_first_id", int_id, 16'd1);
        step();
        step();
        check("prio_first_fall", {15'd0, int_line}, 16'd0);
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        check("prio_gap_int", {15'd0, int_line}, 16'd0);
        step();
        check("prio_idle_int", {15'd0, int_line}, 16'd0);
        check("prio_idle_busy", {15'd0, busy}, 16'd0);
        step();
        check("prio_second_int", {15'd0, int_line}, 16'd1);
        check("prio_second_id", int_id, 16'd3);
        step();
        step();
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();
        check("prio_done_busy", {15'd0, busy}, 16'd0);
        irq_req = '0;

        // Mask: only source 0 enabled, source 2 waits in pending
        cfg_write(16'h0001);
        irq_req = 4'b0100;
        step();
        step();
        step();
        check("mask_blocked_int", {15'd0, int_line}, 16'd0);
        check("mask_blocked_busy", {15'd0, busy}, 16'd0);
        cfg_write(16'h0004);
        check("mask_write_edge_int", {15'd0, int_line}, 16'd0);
        step();
        check("mask_grant_int", {15'd0, int_line}, 16'd1);
        check("mask_grant_id", int_id, 16'd2);
        step();
        step();
        check("mask_wait_int", {15'd0, int_line}, 16'd0);

        // Timeout: no int_done, 8 WAIT_DONE cycles
        for (int i = 0; i < 7; i++) step();
        check("tmo_before_err", {15'd0, err}, 16'd0);
        check("tmo_before_busy", {15'd0, busy}, 16'd1);
        step();
        check("tmo_err", {15'd0, err}, 16'd1);
        check("tmo_gap_busy", {15'd0, busy}, 16'd1);
        step();
        check("tmo_idle_busy", {15'd0, busy}, 16'd0);
        check("tmo_err_sticky", {15'd0, err}, 16'd1);
        cfg_write(16'h400F);
        check("tmo_err_clear", {15'd0, err}, 16'd0);
        irq_req = '0;
        step();

        // Reset in the middle of ASSERT with source 0 held high
        irq_req = 4'b0001;
        step();
        step();
        check("rst_pre_int", {15'd0, int_line}, 16'd1);
        check("rst_pre_id", int_id, 16'd0);
        reset = 1'b0;
        step();
        check("rst_int", {15'd0, int_line}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        step();
        reset = 1'b1;
        cfg_write(16'h000F);
        step();
        step();
        step();
        check("rst_held_no_int", {15'd0, int_line}, 16'd0);
        check("rst_held_no_busy", {15'd0, busy}, 16'd0);
        irq_req = '0;
        step();

        // Early done: int_done during the first ASSERT cycle
        irq_req = 4'b0010;
        step();
        step();
        check("early_int", {15'd0, int_line}, 16'd1);
        check("early_id", int_id, 16'd1);
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        check("early_int_hold", {15'd0, int_line}, 16'd1);
        step();
        check("early_gap_int", {15'd0, int_line}, 16'd0);
        check("early_gap_busy", {15'd0, busy}, 16'd1);
        step();
        check("early_idle_busy", {15'd0, busy}, 16'd0);
        irq_req = '0;
        step();

        // Clear-all-pending collides with a fresh rise: the rise survives
        cfg_write(16'h0000);
        irq_req = 4'b0100;
        step();
        irq_req = 4'b1100;
        cfg_write(16'h8000);
        cfg_write(16'h000F);
        step();
        check("clr_set_wins_int", {15'd0, int_line}, 16'd1);
        check("clr_set_wins_id", int_id, 16'd3);
        step();
        step();
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        step();
        step();
        check("clr_no_second_int", {15'd0, int_line}, 16'd0);
        check("clr_no_second_busy", {15'd0, busy}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
